// File: rtl/whack_detector.sv
// rtl/whack_detector.sv - hammer strike detector with hit/miss classification and saturating scores
//
// Purpose: synchronises per-hole hammer switches, turns switch edges into
// strikes, classifies each strike against the mole mask and keeps saturating
// hit/miss scores.
//
// Ports:
//   clock_i      - system clock, rising edge
//   reset_i      - asynchronous reset, active-low
//   enable_i     - game active; strikes only score while high
//   clear_i      - synchronous clear of both scores (wins over increments)
//   mole_i       - per-hole mole-up mask, synchronous to clock_i
//   hammer_i     - raw per-hole hammer switch levels, asynchronous
//   whacked_o    - 1-cycle pulse, one or more hits this cycle
//   missed_o     - 1-cycle pulse, one or more misses this cycle
//   hit_vec_o    - 1-cycle per-hole hit flags
//   hit_count_o  - saturating hit score
//   miss_count_o - saturating miss score

module whack_detector #(
  parameter int NUM_HOLES   = 16,
  parameter int EDGE_MODE   = 0,
  parameter int SYNC_STAGES = 2,
  parameter int LOCKOUT_CYC = 0,
  parameter int SCORE_W     = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [NUM_HOLES-1:0] mole_i,
  input  logic [NUM_HOLES-1:0] hammer_i,
  output logic                 whacked_o,
  output logic                 missed_o,
  output logic [NUM_HOLES-1:0] hit_vec_o,
  output logic [SCORE_W-1:0]   hit_count_o,
  output logic [SCORE_W-1:0]   miss_count_o
);

  localparam int WW = $clog2(SYNC_STAGES + 2);
  localparam int LW = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;
  localparam int PW = $clog2(NUM_HOLES + 1);
  localparam int SW = ((SCORE_W > PW) ? SCORE_W : PW) + 1;

  localparam logic [WW-1:0]      WARM_LOAD = WW'(SYNC_STAGES + 1);
  localparam logic [LW-1:0]      LOCK_LOAD = LW'(LOCKOUT_CYC);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [SYNC_STAGES-1:0][NUM_HOLES-1:0] sync;
  logic [NUM_HOLES-1:0]                 s;
  logic [NUM_HOLES-1:0]                 prev;
  logic [WW-1:0]                        warm;
  logic [NUM_HOLES-1:0][LW-1:0]         lock;

  logic [NUM_HOLES-1:0] strike;
  logic [NUM_HOLES-1:0] lock_free;
  logic [NUM_HOLES-1:0] qual;
  logic [NUM_HOLES-1:0] hit;
  logic [NUM_HOLES-1:0] miss;
  logic [PW-1:0]        hit_pop;
  logic [PW-1:0]        miss_pop;
  logic [SW-1:0]        hit_sum;
  logic [SW-1:0]        miss_sum;
  logic [SCORE_W-1:0]   hit_next;
  logic [SCORE_W-1:0]   miss_next;

  assign s = sync[SYNC_STAGES-1];

  // Synchroniser chain and previous-level register. prev follows s every
  // cycle so edges seen while disabled, locked out or warming up are consumed.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync <= '0;
      prev <= '0;
    end else begin
      sync[0] <= hammer_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      prev <= s;
    end
  end

  // Warm-up covers the cycles in which a switch held through reset is still
  // propagating through the chain; its apparent edge must not score.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      warm <= WARM_LOAD;
    end else if (warm != '0) begin
      warm <= warm - WW'(1);
    end
  end

  // Per-hole lockout: only a qualified strike reloads; ignored strikes do not.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      lock <= '0;
    end else begin
      for (int i = 0; i < NUM_HOLES; i++) begin
        if (qual[i]) begin
          lock[i] <= LOCK_LOAD;
        end else if (lock[i] != '0) begin
          lock[i] <= lock[i] - LW'(1);
        end
      end
    end
  end

  always_comb begin
    strike = (EDGE_MODE == 0) ? (s ^ prev) : (s & ~prev);
    for (int i = 0; i < NUM_HOLES; i++) begin
      lock_free[i] = (lock[i] == '0);
    end
    qual = (enable_i && (warm == '0)) ? (strike & lock_free) : '0;
    hit  = qual & mole_i;
    miss = qual & ~mole_i;

    hit_pop  = '0;
    miss_pop = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      hit_pop  = hit_pop + PW'(hit[i]);
      miss_pop = miss_pop + PW'(miss[i]);
    end

    // Sums are one bit wider than either operand so saturation is exact.
    hit_sum   = SW'(hit_count_o) + SW'(hit_pop);
    miss_sum  = SW'(miss_count_o) + SW'(miss_pop);
    hit_next  = (hit_sum > SW'(SCORE_MAX)) ? SCORE_MAX : hit_sum[SCORE_W-1:0];
    miss_next = (miss_sum > SW'(SCORE_MAX)) ? SCORE_MAX : miss_sum[SCORE_W-1:0];
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      whacked_o    <= 1'b0;
      missed_o     <= 1'b0;
      hit_vec_o    <= '0;
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      whacked_o <= |hit;
      missed_o  <= |miss;
      hit_vec_o <= hit;
      if (clear_i) begin
        hit_count_o  <= '0;
        miss_count_o <= '0;
      end else begin
        hit_count_o  <= hit_next;
        miss_count_o <= miss_next;
      end
    end
  end

endmodule

// File: tb/tb_whack_detector.sv
// tb/tb_whack_detector.sv - directed self-checking bench for whack_detector

module tb_whack_detector;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [15:0] mole;
  logic [15:0] hammer;

  logic        d_whacked, d_missed;
  logic [15:0] d_hit_vec;
  logic [7:0]  d_hit_count, d_miss_count;

  logic        e_whacked, e_missed;
  logic [15:0] e_hit_vec;
  logic [7:0]  e_hit_count, e_miss_count;

  logic        s_whacked, s_missed;
  logic [15:0] s_hit_vec;
  logic [2:0]  s_hit_count, s_miss_count;

  logic        l_whacked, l_missed;
  logic [15:0] l_hit_vec;
  logic [7:0]  l_hit_count, l_miss_count;

  int checks = 0;
  int fails  = 0;
  logic pulse_seen;

  whack_detector u_def (
    .clock_i(clk), .reset_i(rst), .enable_i(enable), .clear_i(clear),
    .mole_i(mole), .hammer_i(hammer),
    .whacked_o(d_whacked), .missed_o(d_missed), .hit_vec_o(d_hit_vec),
    .hit_count_o(d_hit_count), .miss_count_o(d_miss_count)
  );

  whack_detector #(.EDGE_MODE(1)) u_edge (
    .clock_i(clk), .reset_i(rst), .enable_i(enable), .clear_i(clear),
    .mole_i(mole), .hammer_i(hammer),
    .whacked_o(e_whacked), .missed_o(e_missed), .hit_vec_o(e_hit_vec),
    .hit_count_o(e_hit_count), .miss_count_o(e_miss_count)
  );

  whack_detector #(.SCORE_W(3)) u_sat (
    .clock_i(clk), .reset_i(rst), .enable_i(enable), .clear_i(clear),
    .mole_i(mole), .hammer_i(hammer),
    .whacked_o(s_whacked), .missed_o(s_missed), .hit_vec_o(s_hit_vec),
    .hit_count_o(s_hit_count), .miss_count_o(s_miss_count)
  );

  whack_detector #(.LOCKOUT_CYC(5)) u_lock (
    .clock_i(clk), .reset_i(rst), .enable_i(enable), .clear_i(clear),
    .mole_i(mole), .hammer_i(hammer),
    .whacked_o(l_whacked), .missed_o(l_missed), .hit_vec_o(l_hit_vec),
    .hit_count_o(l_hit_count), .miss_count_o(l_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pulse_seen = pulse_seen | d_whacked | d_missed;
    end
  endtask

  task automatic do_reset(input logic [15:0] h);
    rst = 1'b0;
    hammer = h;
    tick(2);
    rst = 1'b1;
    tick(10);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b1; clear = 1'b0; mole = '0; hammer = '0;
    pulse_seen = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (d_whacked !== 1'b0) begin fails++; $display("FAIL reset_whacked got %b want 0", d_whacked); end
    checks++; if (d_missed !== 1'b0) begin fails++; $display("FAIL reset_missed got %b want 0", d_missed); end
    checks++; if (d_hit_vec !== 16'h0000) begin fails++; $display("FAIL reset_hit_vec got %h want 0000", d_hit_vec); end
    checks++; if (d_hit_count !== 8'd0) begin fails++; $display("FAIL reset_hit_count got %0d want 0", d_hit_count); end
    checks++; if (d_miss_count !== 8'd0) begin fails++; $display("FAIL reset_miss_count got %0d want 0", d_miss_count); end
  endtask

  task automatic test_single_hit;
    do_reset(16'h0000);
    mole = 16'h0008;
    hammer = 16'h0008;
    tick(2);
    checks++; if (d_whacked !== 1'b0) begin fails++; $display("FAIL hit_early got %b want 0", d_whacked); end
    tick(1);
    checks++; if (d_whacked !== 1'b1) begin fails++; $display("FAIL hit_pulse got %b want 1", d_whacked); end
    checks++; if (d_hit_vec !== 16'h0008) begin fails++; $display("FAIL hit_vec got %h want 0008", d_hit_vec); end
    checks++; if (d_hit_count !== 8'd1) begin fails++; $display("FAIL hit_count got %0d want 1", d_hit_count); end
    tick(1);
    checks++; if (d_whacked !== 1'b0) begin fails++; $display("FAIL hit_pulse_end got %b want 0", d_whacked); end
    checks++; if (d_hit_vec !== 16'h0000) begin fails++; $display("FAIL hit_vec_end got %h want 0000", d_hit_vec); end
  endtask

  task automatic test_miss_and_edge_mode;
    mole = 16'h0000;
    hammer = 16'h0028;
    tick(3);
    checks++; if (d_missed !== 1'b1) begin fails++; $display("FAIL miss_pulse got %b want 1", d_missed); end
    checks++; if (d_miss_count !== 8'd1) begin fails++; $display("FAIL miss_count got %0d want 1", d_miss_count); end
    checks++; if (d_hit_count !== 8'd1) begin fails++; $display("FAIL miss_hit_unchanged got %0d want 1", d_hit_count); end
    checks++; if (e_miss_count !== 8'd1) begin fails++; $display("FAIL edge_rise_miss got %0d want 1", e_miss_count); end
    tick(1);
    checks++; if (d_missed !== 1'b0) begin fails++; $display("FAIL miss_pulse_end got %b want 0", d_missed); end
    hammer = 16'h0000;
    tick(3);
    checks++; if (d_missed !== 1'b1) begin fails++; $display("FAIL toggle_fall_miss got %b want 1", d_missed); end
    checks++; if (d_miss_count !== 8'd3) begin fails++; $display("FAIL toggle_fall_count got %0d want 3", d_miss_count); end
    checks++; if (e_missed !== 1'b0) begin fails++; $display("FAIL edge_fall_pulse got %b want 0", e_missed); end
    checks++; if (e_miss_count !== 8'd1) begin fails++; $display("FAIL edge_fall_miss got %0d want 1", e_miss_count); end
    checks++; if (e_hit_count !== 8'd1) begin fails++; $display("FAIL edge_fall_hit got %0d want 1", e_hit_count); end
  endtask

  task automatic test_multi_hit;
    mole = 16'hFFFF;
    do_reset(16'h0000);
    hammer = 16'h000F;
    tick(3);
    checks++; if (d_whacked !== 1'b1) begin fails++; $display("FAIL multi_pulse got %b want 1", d_whacked); end
    checks++; if (d_hit_vec !== 16'h000F) begin fails++; $display("FAIL multi_vec got %h want 000f", d_hit_vec); end
    checks++; if (d_hit_count !== 8'd4) begin fails++; $display("FAIL multi_count got %0d want 4", d_hit_count); end
    checks++; if (d_missed !== 1'b0) begin fails++; $display("FAIL multi_no_miss got %b want 0", d_missed); end
    tick(1);
    checks++; if (d_whacked !== 1'b0) begin fails++; $display("FAIL multi_single_pulse got %b want 0", d_whacked); end
  endtask

  task automatic test_saturate_clear;
    logic [2:0] exp;
    mole = 16'hFFFF;
    do_reset(16'h0000);
    for (int i = 1; i <= 9; i++) begin
      hammer = hammer ^ 16'h0001;
      tick(3);
      exp = (i > 7) ? 3'd7 : 3'(i);
      checks++; if (s_hit_count !== exp) begin fails++; $display("FAIL sat_count_%0d got %0d want %0d", i, s_hit_count, exp); end
    end
    hammer = hammer ^ 16'h0001;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checks++; if (s_hit_count !== 3'd0) begin fails++; $display("FAIL clear_count got %0d want 0", s_hit_count); end
    checks++; if (s_whacked !== 1'b1) begin fails++; $display("FAIL clear_pulse got %b want 1", s_whacked); end
    tick(1);
    checks++; if (s_hit_count !== 3'd0) begin fails++; $display("FAIL clear_hold got %0d want 0", s_hit_count); end
  endtask

  task automatic test_lockout;
    mole = 16'h0001;
    do_reset(16'h0000);
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || c == 2 || c == 7) hammer = hammer ^ 16'h0001;
      tick(1);
    end
    tick(3);
    checks++; if (l_hit_count !== 8'd2) begin fails++; $display("FAIL lockout_count got %0d want 2", l_hit_count); end
    checks++; if (l_miss_count !== 8'd0) begin fails++; $display("FAIL lockout_miss got %0d want 0", l_miss_count); end
    checks++; if (d_hit_count !== 8'd3) begin fails++; $display("FAIL no_lockout_count got %0d want 3", d_hit_count); end
  endtask

  task automatic test_disable_and_reset;
    mole = 16'h0000;
    pulse_seen = 1'b0;
    do_reset(16'h0001);
    tick(5);
    checks++; if (pulse_seen !== 1'b0) begin fails++; $display("FAIL held_switch_pulse got %b want 0", pulse_seen); end
    checks++; if (d_miss_count !== 8'd0) begin fails++; $display("FAIL held_switch_miss got %0d want 0", d_miss_count); end
    enable = 1'b0;
    hammer = 16'h0000;
    tick(5);
    enable = 1'b1;
    tick(4);
    checks++; if (pulse_seen !== 1'b0) begin fails++; $display("FAIL disabled_pulse got %b want 0", pulse_seen); end
    checks++; if (d_miss_count !== 8'd0) begin fails++; $display("FAIL disabled_miss got %0d want 0", d_miss_count); end
    checks++; if (d_hit_count !== 8'd0) begin fails++; $display("FAIL disabled_hit got %0d want 0", d_hit_count); end
    mole = 16'h0001;
    hammer = 16'h0001;
    tick(3);
    checks++; if (d_whacked !== 1'b1) begin fails++; $display("FAIL pre_reset_hit got %b want 1", d_whacked); end
    #2 rst = 1'b0;
    #1;
    checks++; if (d_whacked !== 1'b0) begin fails++; $display("FAIL async_reset_whacked got %b want 0", d_whacked); end
    checks++; if (d_hit_vec !== 16'h0000) begin fails++; $display("FAIL async_reset_vec got %h want 0000", d_hit_vec); end
    checks++; if (d_hit_count !== 8'd0) begin fails++; $display("FAIL async_reset_count got %0d want 0", d_hit_count); end
    tick(1);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_miss_and_edge_mode();
    test_multi_hit();
    test_saturate_clear();
    test_lockout();
    test_disable_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
